// File: rtl/press_pkg.sv
// Shared types and timing constants for the press-pattern player and the
// short/long press classifier, so both sides agree on what "short" and "long" mean.
package press_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_TICK_DIV    = 25000;
    localparam int DEF_SHORT_TICKS = 1000;
    localparam int DEF_LONG_TICKS  = 5000;
    localparam int DEF_GAP_TICKS   = 1000;

    // Classifier decision thresholds: a short mark must stay below SHORT_MAX,
    // a long mark must reach LONG_MIN.
    localparam int SHORT_MAX = 2000;
    localparam int LONG_MIN  = 4000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running TICK_DIV divider: one-cycle tick each time the count wraps,
// synchronous clear restarts the period from zero.
module tick_prescaler
    import press_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = (cnt == W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/press_pattern_player.sv
// Plays an NBITS value MSB first on one LED line: long mark for 1, short mark
// for 0, fixed gap after each mark. Optional abort input under PLAYER_ABORT_EN.
module press_pattern_player
    import press_pkg::*;
#(
    parameter int NBITS       = 3,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SHORT_TICKS = DEF_SHORT_TICKS,
    parameter int LONG_TICKS  = DEF_LONG_TICKS,
    parameter int GAP_TICKS   = DEF_GAP_TICKS,
    localparam int BW         = (NBITS > 1) ? $clog2(NBITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NBITS-1:0] data,
`ifdef PLAYER_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic             led_out,
    output logic [BW-1:0]    bit_idx
);

    localparam int TW = $clog2(max3(SHORT_TICKS, LONG_TICKS, GAP_TICKS) + 1);
    localparam logic [TW-1:0] SHORT_LAST = TW'(SHORT_TICKS - 1);
    localparam logic [TW-1:0] LONG_LAST  = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);

    state_t           state, nstate;
    logic [NBITS-1:0] sreg;
    logic [TW-1:0]    tcnt;
    logic [TW-1:0]    phase_last;
    logic             tick, clr, phase_end, abort_hit;

    // Counters restart on every phase change and sit at zero while idle.
    assign clr = (nstate != state) || (state == IDLE);

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .tick (tick)
    );

    always_comb begin
        nstate     = state;
        abort_hit  = 1'b0;
        phase_last = GAP_LAST;
        if (state == MARK)
            phase_last = sreg[NBITS-1] ? LONG_LAST : SHORT_LAST;
        phase_end = tick && (tcnt == phase_last);
`ifdef PLAYER_ABORT_EN
        abort_hit = abort && ((state == MARK) || (state == SPACE));
`endif
        case (state)
            IDLE:    if (start) nstate = MARK;
            MARK:    if (phase_end) nstate = SPACE;
            SPACE:   if (phase_end) nstate = (bit_idx == '0) ? DONE : MARK;
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
        if (abort_hit)
            nstate = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tcnt    <= '0;
            sreg    <= '0;
            bit_idx <= BW'(NBITS - 1);
            busy    <= 1'b0;
            done    <= 1'b0;
            led_out <= 1'b0;
        end else begin
            state <= nstate;
            if (clr)
                tcnt <= '0;
            else if (tick)
                tcnt <= tcnt + TW'(1);
            if (state == IDLE && start) begin
                sreg    <= data;
                bit_idx <= BW'(NBITS - 1);
            end else if (state == SPACE && nstate == MARK) begin
                sreg    <= sreg << 1;
                bit_idx <= bit_idx - BW'(1);
            end
            // Outputs are registered from the next state so the LED pin is glitch-free.
            led_out <= (nstate == MARK);
            busy    <= (nstate == MARK) || (nstate == SPACE);
            done    <= (nstate == DONE);
        end
    end

endmodule

// File: tb/tb_press_pattern_player.sv
// Self-checking bench for press_pattern_player: expected LED waveform is built
// per pattern from the bit/length rules and compared cycle by cycle.
module tb_press_pattern_player;

    localparam int NB = 3;
    localparam int TD = 2;
    localparam int ST = 2;
    localparam int LT = 5;
    localparam int GT = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NB-1:0] data;
    logic          busy, done, led_out;
    logic [1:0]    bit_idx;
`ifdef PLAYER_ABORT_EN
    logic          abort;
`endif

    int errors = 0;
    int checks = 0;
    bit exp_led[$];
    int exp_idx[$];

    press_pattern_player #(
        .NBITS(NB), .TICK_DIV(TD), .SHORT_TICKS(ST), .LONG_TICKS(LT), .GAP_TICKS(GT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .data   (data),
`ifdef PLAYER_ABORT_EN
        .abort  (abort),
`endif
        .busy   (busy),
        .done   (done),
        .led_out(led_out),
        .bit_idx(bit_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Reference waveform: per bit MSB first, a mark of LEN ticks then a gap.
    task automatic build(input logic [NB-1:0] d);
        exp_led.delete();
        exp_idx.delete();
        for (int b = NB - 1; b >= 0; b--) begin
            int len;
            len = d[b] ? LT : ST;
            repeat (len * TD) begin exp_led.push_back(1'b1); exp_idx.push_back(b); end
            repeat (GT * TD)  begin exp_led.push_back(1'b0); exp_idx.push_back(b); end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge showing done.
    task automatic play(input logic [NB-1:0] d, input bit keep, input int ign_at, input string tag);
        build(d);
        start = 1'b1;
        data  = d;
        for (int i = 0; i < exp_led.size(); i++) begin
            @(negedge clk);
            if (i == 0 && !keep) start = 1'b0;
            if (i == ign_at) begin
                start = 1'b1;
                data  = ~d;
            end else if (i == ign_at + 1 && !keep) begin
                start = 1'b0;
            end
            chk({tag, "_play"}, {3'b0, led_out, busy, done, bit_idx},
                {3'b0, exp_led[i], 1'b1, 1'b0, 2'(exp_idx[i])});
        end
        @(negedge clk);
        start = keep;
        chk({tag, "_done"}, {3'b0, led_out, busy, done, bit_idx}, {3'b0, 1'b0, 1'b0, 1'b1, 2'd0});
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        chk(tag, {5'b0, led_out, busy, done}, 8'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        data  = '0;
`ifdef PLAYER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset", {3'b0, led_out, busy, done, bit_idx}, {3'b0, 3'b000, 2'd2});
        rst_n = 1'b1;
        idle_chk("idle_after_reset");

        // Directed patterns; a start with new data mid-play must be ignored.
        play(3'b101, 1'b0, -1, "s1_101");
        idle_chk("s1_idle");
        play(3'b000, 1'b0, -1, "s2_000");
        idle_chk("s2_idle");
        play(3'b111, 1'b0, 4, "s3_111");
        idle_chk("s3_idle");

        // Reset in the middle of the second bit's mark.
        start = 1'b1;
        data  = 3'b011;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("s4_mid_mark", {5'b0, led_out, bit_idx}, {5'b0, 1'b1, 2'd1});
        rst_n = 1'b0;
        #1;
        chk("s4_async_reset", {3'b0, led_out, busy, done, bit_idx}, {3'b0, 3'b000, 2'd2});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) idle_chk("s4_no_done");
        play(3'b101, 1'b0, -1, "s4_replay");
        idle_chk("s4_idle");

        // Start held high: DONE, exactly one IDLE cycle, then the next pattern.
        play(3'b010, 1'b1, -1, "s5_first");
        idle_chk("s5_gap");
        play(3'b010, 1'b1, -1, "s5_second");
        start = 1'b0;
        idle_chk("s5_idle");

        // Random patterns with a random ignored start/data change during play.
        for (int n = 0; n < 8; n++) begin
            int gap;
            play(NB'($urandom_range(0, 7)), 1'b0, int'($urandom_range(2, 25)), "rand");
            gap = int'($urandom_range(1, 3));
            for (int g = 0; g < gap; g++) idle_chk("rand_idle");
        end

`ifdef PLAYER_ABORT_EN
        // Abort on the third cycle of the first mark.
        start = 1'b1;
        data  = 3'b101;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("s6_in_mark", {6'b0, led_out, busy}, 8'd3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("s6_abort_done", {5'b0, led_out, busy, done}, 8'd1);
        idle_chk("s6_idle");
        abort = 1'b1;
        idle_chk("s6_abort_idle");
        abort = 1'b0;
        play(3'b001, 1'b0, -1, "s6_after");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
